seg7_serial_driver: RTL and testbench
=====================================

SEG7_SERIAL_DRIVER -- requirements
Module: seg7_serial_driver

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DIGITS, 8, number of 7-segment digits driven (1..16).
- CLK_DIV, 2, system clocks per half period of seg_clk (>=1).
- BLINK_DIV, 25000000, system clocks per blink phase (>=2).
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, system clock; all logic on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- hex, in, 4*DIGITS, digit values; digit i is hex[4i+3:4i].
- point, in, DIGITS, decimal point on per digit; active-high.
- LE, in, DIGITS, per-digit blank; active-high.
- blink, in, DIGITS, per-digit blink enable.
- lz_en, in, 1, enables leading-zero blanking.
- auto_refresh, in, 1, restarts frames continuously.
- start, in, 1, one-cycle frame request.
- seg_clk, out, 1, serial shift clock to the external shift-register chain.
- seg_sout, out, 1, serial data.
- seg_pen, out, 1, latch pulse to the external shift-register chain.
- busy, out, 1, frame in progress.
- done, out, 1, one-cycle pulse at frame end.

Function
REQ-003 Each digit SHALL produce one byte: bits[6:0] = segments a..g, bit7 = dp; all bits active-low (0 = lit).
REQ-004 Hex codes SHALL be 0-F = C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E (dp off), with bit7 = ~point[i].
REQ-005 A digit SHALL be forced to 0xFF when LE[i]=1, when blink[i]=1 and blink phase=1, or when it is leading-blanked.
REQ-006 Leading blank: with lz_en=1, digit i (i>=1) SHALL be blanked when digits i..DIGITS-1 are all zero; digit 0 is never leading-blanked.
REQ-007 Blink phase SHALL toggle every BLINK_DIV clocks from a free-running counter that is independent of the frame FSM.
REQ-008 FSM states SHALL be IDLE, LOAD, SHIFT_LO, SHIFT_HI and LATCH.
REQ-009 IDLE->LOAD on start=1 or auto_refresh=1. LOAD is 1 cycle and snapshots all 8*DIGITS pattern bits.
REQ-010 Input changes after LOAD SHALL NOT affect the frame in flight.
REQ-011 SHIFT_LO (seg_clk=0, CLK_DIV cycles) SHALL present the next bit on seg_sout; SHIFT_HI (seg_clk=1, CLK_DIV cycles) SHALL hold it.
REQ-012 Shift order SHALL be MSB first: snapshot bit 8*DIGITS-1 first, bit 0 last.
REQ-013 After SHIFT_HI of the final bit, the FSM SHALL enter LATCH: seg_pen=1 and seg_clk=0 for CLK_DIV cycles.
REQ-014 On leaving LATCH, done SHALL be 1 for exactly one cycle and the FSM SHALL return to IDLE.
REQ-015 Frame length from the LOAD cycle through the last LATCH cycle SHALL be 1 + 16*DIGITS*CLK_DIV + CLK_DIV clocks; for DIGITS=8, CLK_DIV=2 this is 259.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 start while busy SHALL set a pending flag (multiple requests merge into one). A pending flag or auto_refresh=1 SHALL cause IDLE->LOAD on the cycle after done.
REQ-018 The bit counter SHALL be clog2(8*DIGITS) bits wide, and the divider counter clog2(CLK_DIV)+1 bits wide; neither counter SHALL wrap within a frame.

Reset
REQ-019 rst_n=0 SHALL asynchronously force: state=IDLE, seg_clk=0, seg_sout=1, seg_pen=0, busy=0, done=0, pending=0, blink phase=0, all counters=0.
REQ-020 Reset asserted mid-frame SHALL abort the frame; no seg_pen pulse SHALL follow. After release, nothing SHALL be emitted until the next start or auto_refresh.

Structure
REQ-021 A shared package SHALL hold the FSM state enum, the 16-entry segment code table and the blank byte constant 8'hFF.
REQ-022 A sub-module seg7_hex_decode (4-bit hex in, 7-bit active-low segments out) SHALL be instantiated once per digit via generate.

Verification
REQ-023 Bench: DIGITS=8, CLK_DIV=2, hex=0x00000001, lz_en=1, start pulse -> 64 bits shifted as FF x7 then F9; one seg_pen pulse; done at cycle 260 after start.
REQ-024 Bench: hex=0x76543210, point=0x01, LE=0x80, lz_en=0 -> bytes sent FF,82,92,99,B0,A4,F9,40.
REQ-025 Bench: blink=0x01, BLINK_DIV=300, auto_refresh=1 -> digit 0 alternates C0/FF across frames as the blink phase flips; the other digits are constant.
REQ-026 Bench: start pulsed 3 times mid-frame -> exactly one further frame, starting the cycle after done; hex changed mid-frame -> current frame unchanged.
REQ-027 Bench: rst_n=0 at bit 30 -> all outputs at reset values in the same cycle; no seg_pen pulse; idle after release.
REQ-028 Bench: DIGITS=1, CLK_DIV=1 -> 8 bits, frame = 1+16+1 = 18 cycles, done on the following cycle.

Source files
------------

// File: rtl/seg7_serial_driver_pkg.sv
// Shared types and constants for the serial 7-segment driver.
// Holds the frame FSM state enum, the hex-to-segment code table and the blank byte.
// Codes are active-low with the decimal point off (bit7 = 1).
package seg7_serial_driver_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    LATCH    = 3'd4
  } state_t;

  localparam logic [7:0] BLANK_BYTE = 8'hFF;

  // Entry h is the byte for hex digit h; entry 0 sits in the least significant byte.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// One hex nibble to active-low segments a..g (bit0 = a).
// Purely combinational, zero latency.
// No handshake; output follows input.
module seg7_hex_decode
  import seg7_serial_driver_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[hex][6:0];

endmodule

// File: rtl/seg7_serial_driver.sv
// Serialises one byte per digit (MSB first) into an external shift-register chain, then latches.
// Frame = 1 load + 16*DIGITS*CLK_DIV shift + CLK_DIV latch clocks; done pulses the cycle after.
// Requests during a frame merge into one pending frame started right after done.
module seg7_serial_driver
  import seg7_serial_driver_pkg::*;
#(
  parameter int DIGITS    = 8,
  parameter int CLK_DIV   = 2,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   hex,
  input  logic [DIGITS-1:0]     point,
  input  logic [DIGITS-1:0]     LE,
  input  logic [DIGITS-1:0]     blink,
  input  logic                  lz_en,
  input  logic                  auto_refresh,
  input  logic                  start,
  output logic                  seg_clk,
  output logic                  seg_sout,
  output logic                  seg_pen,
  output logic                  busy,
  output logic                  done
);

  localparam int NBITS = 8 * DIGITS;
  localparam int BW    = $clog2(NBITS);
  localparam int DW    = $clog2(CLK_DIV) + 1;
  localparam int KW    = $clog2(BLINK_DIV);

  localparam logic [BW-1:0] BIT_LAST   = BW'(NBITS - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [KW-1:0] BLINK_LAST = KW'(BLINK_DIV - 1);

  state_t            state, state_nxt;
  logic [BW-1:0]     bit_cnt;
  logic [DW-1:0]     div_cnt;
  logic [KW-1:0]     blink_cnt;
  logic              blink_phase;
  logic [NBITS-1:0]  shreg;
  logic [NBITS-1:0]  pattern;
  logic [DIGITS-1:0] zero_above;
  logic [6:0]        seg [DIGITS];
  logic              pending;
  logic              done_q;
  logic              div_end;
  logic              bit_end;

  assign div_end = (div_cnt == DIV_LAST);
  assign bit_end = (bit_cnt == BIT_LAST);
  assign done    = done_q;

  // Free-running blink phase, deliberately unrelated to frame timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_dec
    seg7_hex_decode u_dec (
      .hex (hex[4*i +: 4]),
      .seg (seg[i])
    );
  end

  // zero_above[i]: digit i and every more significant digit are zero.
  always_comb begin
    zero_above = '0;
    zero_above[DIGITS-1] = (hex[4*DIGITS-1 -: 4] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      zero_above[i] = zero_above[i+1] & (hex[4*i +: 4] == 4'd0);
    end
  end

  // Live frame image; digit DIGITS-1 occupies the top byte so it leaves first.
  always_comb begin
    pattern = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (LE[i] || (blink[i] && blink_phase) || (lz_en && (i != 0) && zero_above[i]))
        pattern[8*i +: 8] = BLANK_BYTE;
      else
        pattern[8*i +: 8] = {~point[i], seg[i]};
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and pin decode; outputs come straight from state so reset clears them at once.
  always_comb begin
    state_nxt = state;
    seg_clk   = 1'b0;
    seg_sout  = 1'b1;
    seg_pen   = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start || pending || auto_refresh) state_nxt = LOAD;
      end
      LOAD: state_nxt = SHIFT_LO;
      SHIFT_LO: begin
        seg_sout = shreg[NBITS-1];
        if (div_end) state_nxt = SHIFT_HI;
      end
      SHIFT_HI: begin
        seg_clk  = 1'b1;
        seg_sout = shreg[NBITS-1];
        if (div_end) state_nxt = bit_end ? LATCH : SHIFT_LO;
      end
      LATCH: begin
        seg_pen = 1'b1;
        if (div_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Snapshot, shift, divider/bit counting, merged request flag and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      pending <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state == LATCH) && div_end;
      // IDLE always leaves when a request exists, so the flag is consumed there.
      if (state == IDLE)  pending <= 1'b0;
      else if (start)     pending <= 1'b1;
      unique case (state)
        LOAD: begin
          shreg   <= pattern;
          div_cnt <= '0;
          bit_cnt <= '0;
        end
        SHIFT_LO: div_cnt <= div_end ? '0 : div_cnt + 1'b1;
        SHIFT_HI: begin
          if (div_end) begin
            div_cnt <= '0;
            if (!bit_end) begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= {shreg[NBITS-2:0], 1'b0};
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        LATCH: begin
          if (div_end) begin
            div_cnt <= '0;
            bit_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_serial_driver.sv
// Bench for seg7_serial_driver: an 8-digit instance and a 1-digit instance.
// Stimulus pushes expected frame images; monitors rebuild frames from the serial pins.
// Monitors compare on each latch pulse.
module tb_seg7_serial_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [31:0] hex_a;
  logic [7:0]  point_a, le_a, blink_a;
  logic        lz_a, auto_a, start_a;
  logic        sclk_a, sout_a, pen_a, busy_a, done_a;

  logic [3:0]  hex_b;
  logic        point_b, le_b, blink_b, lz_b, auto_b, start_b;
  logic        sclk_b, sout_b, pen_b, busy_b, done_b;

  int checks   = 0;
  int failures = 0;

  logic [63:0] q_a[$];
  logic [63:0] q_b[$];
  int pens_a = 0, pens_b = 0, pushed_a = 0, pushed_b = 0;

  seg7_serial_driver #(.DIGITS(8), .CLK_DIV(2), .BLINK_DIV(300)) dut_a (
    .clk(clk), .rst_n(rst_n), .hex(hex_a), .point(point_a), .LE(le_a), .blink(blink_a),
    .lz_en(lz_a), .auto_refresh(auto_a), .start(start_a),
    .seg_clk(sclk_a), .seg_sout(sout_a), .seg_pen(pen_a), .busy(busy_a), .done(done_a)
  );

  seg7_serial_driver #(.DIGITS(1), .CLK_DIV(1), .BLINK_DIV(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .hex(hex_b), .point(point_b), .LE(le_b), .blink(blink_b),
    .lz_en(lz_b), .auto_refresh(auto_b), .start(start_b),
    .seg_clk(sclk_b), .seg_sout(sout_b), .seg_pen(pen_b), .busy(busy_b), .done(done_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor A: collect bits on seg_clk rising, compare on seg_pen rising.
  logic [63:0] acc_a = '0;
  int          nb_a = 0;
  logic        pclk_a = 1'b0, ppen_a = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_a = '0; nb_a = 0; pclk_a = 1'b0; ppen_a = 1'b0;
    end else begin
      if (sclk_a && !pclk_a) begin
        acc_a = {acc_a[62:0], sout_a};
        nb_a++;
      end
      if (pen_a && !ppen_a) begin
        pens_a++;
        if (q_a.size() == 0) begin
          check("a_unexpected_frame", acc_a, 64'hX);
        end else begin
          check("a_frame", acc_a, q_a.pop_front());
          check("a_bitcount", nb_a, 64);
        end
        acc_a = '0; nb_a = 0;
      end
      pclk_a = sclk_a; ppen_a = pen_a;
    end
  end

  // Monitor B: same for the single-digit instance.
  logic [63:0] acc_b = '0;
  int          nb_b = 0;
  logic        pclk_b = 1'b0, ppen_b = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_b = '0; nb_b = 0; pclk_b = 1'b0; ppen_b = 1'b0;
    end else begin
      if (sclk_b && !pclk_b) begin
        acc_b = {acc_b[62:0], sout_b};
        nb_b++;
      end
      if (pen_b && !ppen_b) begin
        pens_b++;
        if (q_b.size() == 0) begin
          check("b_unexpected_frame", acc_b, 64'hX);
        end else begin
          check("b_frame", acc_b, q_b.pop_front());
          check("b_bitcount", nb_b, 8);
        end
        acc_b = '0; nb_b = 0;
      end
      pclk_b = sclk_b; ppen_b = pen_b;
    end
  end

  // Pulse start on A; cyc = cycle index (LOAD = 1) at which done is seen, 0 on timeout.
  task automatic frame_a(output int cyc);
    cyc = 0;
    @(negedge clk);
    start_a = 1'b1;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (c == 1) start_a = 1'b0;
      if (done_a) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic frame_b(output int cyc);
    cyc = 0;
    @(negedge clk);
    start_b = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) start_b = 1'b0;
      if (done_b) begin
        cyc = c;
        break;
      end
    end
  endtask

  localparam logic [63:0] BLINK_ON  = 64'hC0C0C0C0C0C0C0C0;
  localparam logic [63:0] BLINK_OFF = 64'hC0C0C0C0C0C0C0FF;

  initial begin
    int cyc, c1, c2, extra, bad, pens_before;
    logic rs;
    logic [63:0] blink_exp [6];

    rst_n = 1'b0;
    hex_a = '0; point_a = '0; le_a = '0; blink_a = '0; lz_a = 1'b0; auto_a = 1'b0; start_a = 1'b0;
    hex_b = '0; point_b = 1'b0; le_b = 1'b0; blink_b = 1'b0; lz_b = 1'b0; auto_b = 1'b0; start_b = 1'b0;

    // Reset values on both instances.
    repeat (3) @(negedge clk);
    check("reset_pins_a", {sclk_a, sout_a, pen_a, busy_a, done_a}, 5'b01000);
    check("reset_pins_b", {sclk_b, sout_b, pen_b, busy_b, done_b}, 5'b01000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Leading-zero blanking, frame timing.
    hex_a = 32'h00000001; lz_a = 1'b1;
    q_a.push_back(64'hFFFFFFFFFFFFFFF9); pushed_a++;
    frame_a(cyc);
    check("lz_done_cycle", cyc, 260);

    // Per-digit blank, decimal point, full table slice.
    hex_a = 32'h76543210; point_a = 8'h01; le_a = 8'h80; lz_a = 1'b0;
    q_a.push_back(64'hFF829299B0A4F940); pushed_a++;
    frame_a(cyc);
    check("le_dp_done_cycle", cyc, 260);

    // Merged mid-frame starts, mid-frame data change.
    point_a = '0; le_a = '0;
    hex_a = 32'h89ABCDEF;
    q_a.push_back(64'h80908883C6A1868E); pushed_a++;
    q_a.push_back(64'hC0C0C0C0C0C0A4C0); pushed_a++;
    c1 = 0; c2 = 0; extra = 0; rs = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    for (int c = 1; c <= 900; c++) begin
      @(negedge clk);
      start_a = (c == 20) || (c == 60) || (c == 61) || (c == 100);
      if (c == 50) hex_a = 32'h00000020;
      if (done_a) begin
        if (c1 == 0)      c1 = c;
        else if (c2 == 0) c2 = c;
        else              extra++;
      end
      if (c1 != 0 && c == c1 + 1) rs = busy_a;
    end
    check("merge_first_done", c1, 260);
    check("merge_restart_next_cycle", rs, 1'b1);
    check("merge_second_len", c2 - c1, 260);
    check("merge_no_extra_frame", extra, 0);

    // Reset during bit 30 of a frame.
    hex_a = 32'h12345678;
    pens_before = pens_a;
    @(negedge clk);
    start_a = 1'b1;
    for (int c = 1; c <= 123; c++) begin
      @(negedge clk);
      if (c == 1) start_a = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1 check("midframe_reset_pins", {sclk_a, sout_a, pen_a, busy_a, done_a}, 5'b01000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (busy_a || pen_a || sclk_a || done_a) bad++;
    end
    check("post_reset_idle_cycles", bad, 0);
    check("post_reset_no_latch", pens_a, pens_before);

    // Blink under auto-refresh: frames load after edges 1+260n, phase flips every 300.
    blink_exp = '{BLINK_ON, BLINK_ON, BLINK_OFF, BLINK_ON, BLINK_OFF, BLINK_ON};
    hex_a = '0; lz_a = 1'b0; blink_a = 8'h01;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    auto_a = 1'b1;
    for (int n = 0; n < 6; n++) begin
      q_a.push_back(blink_exp[n]);
      pushed_a++;
    end
    repeat (1400) @(posedge clk);
    @(negedge clk);
    auto_a = 1'b0;
    for (int i = 0; i < 600 && q_a.size() != 0; i++) @(negedge clk);
    check("blink_frames_drained", q_a.size(), 0);
    repeat (10) @(negedge clk);
    check("blink_stopped", busy_a, 1'b0);

    // Single digit, divide-by-one.
    hex_b = 4'h3; point_b = 1'b1; lz_b = 1'b1;
    q_b.push_back(64'h30); pushed_b++;
    frame_b(cyc);
    check("one_digit_done_cycle", cyc, 19);
    repeat (5) @(negedge clk);

    check("a_latch_count", pens_a, pushed_a);
    check("b_latch_count", pens_b, pushed_b);
    check("b_queue_empty", q_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
